// File: rtl/memoria_corte_param.sv
// Cut-program memory with playback sequencer: a loader fills a dual-port RAM and the
// sequencer streams words from a start address until an end marker, an abort or the top of memory.
module memoria_corte_param #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 9,
    parameter logic [DATA_WIDTH-1:0] END_MARKER = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  escribir,
    input  logic [ADDR_WIDTH-1:0] direccion_escribir,
    input  logic [DATA_WIDTH-1:0] dato_escribir,
    input  logic                  iniciar,
    input  logic [ADDR_WIDTH-1:0] direccion_inicio,
    input  logic                  detener,
    input  logic                  dato_aceptado,
    output logic [DATA_WIDTH-1:0] dato_salida,
    output logic                  dato_valido,
    output logic                  ocupado,
    output logic                  corte_terminado,
    output logic                  error_sin_fin,
    output logic [ADDR_WIDTH:0]   palabras_entregadas
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ULTIMA  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] UNO_PTR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   UNO_CNT = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {REPOSO, LEER, CAPTURA, ENTREGA} estado_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] lectura_q;

    estado_t               estado_q, estado_d;
    logic [ADDR_WIDTH-1:0] puntero_q, puntero_d;
    logic [DATA_WIDTH-1:0] salida_q, salida_d;
    logic                  valido_q, valido_d;
    logic                  ocupado_q, ocupado_d;
    logic                  terminado_q, terminado_d;
    logic                  sin_fin_q, sin_fin_d;
    logic [ADDR_WIDTH:0]   cuenta_q, cuenta_d;

    // Program storage is never reset; nonblocking read/write gives read-first behaviour.
    always_ff @(posedge clock) begin
        if (escribir) begin
            mem[direccion_escribir] <= dato_escribir;
        end
        if (estado_q == LEER) begin
            lectura_q <= mem[puntero_q];
        end
    end

    always_comb begin
        estado_d    = estado_q;
        puntero_d   = puntero_q;
        salida_d    = salida_q;
        valido_d    = valido_q;
        terminado_d = 1'b0;
        sin_fin_d   = 1'b0;
        cuenta_d    = cuenta_q;

        // An abort wins over both an accept and a marker seen in the same cycle.
        if ((estado_q != REPOSO) && detener) begin
            estado_d = REPOSO;
            valido_d = 1'b0;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (iniciar) begin
                        puntero_d = direccion_inicio;
                        cuenta_d  = '0;
                        estado_d  = LEER;
                    end
                end
                LEER: begin
                    estado_d = CAPTURA;
                end
                CAPTURA: begin
                    if (lectura_q == END_MARKER) begin
                        terminado_d = 1'b1;
                        estado_d    = REPOSO;
                    end else begin
                        salida_d = lectura_q;
                        valido_d = 1'b1;
                        estado_d = ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (dato_aceptado) begin
                        valido_d = 1'b0;
                        cuenta_d = cuenta_q + UNO_CNT;
                        if (puntero_q == ULTIMA) begin
                            sin_fin_d = 1'b1;
                            estado_d  = REPOSO;
                        end else begin
                            puntero_d = puntero_q + UNO_PTR;
                            estado_d  = LEER;
                        end
                    end
                end
                default: begin
                    estado_d = REPOSO;
                end
            endcase
        end

        ocupado_d = (estado_d != REPOSO);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= REPOSO;
            puntero_q   <= '0;
            salida_q    <= '0;
            valido_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            terminado_q <= 1'b0;
            sin_fin_q   <= 1'b0;
            cuenta_q    <= '0;
        end else begin
            estado_q    <= estado_d;
            puntero_q   <= puntero_d;
            salida_q    <= salida_d;
            valido_q    <= valido_d;
            ocupado_q   <= ocupado_d;
            terminado_q <= terminado_d;
            sin_fin_q   <= sin_fin_d;
            cuenta_q    <= cuenta_d;
        end
    end

    assign dato_salida         = salida_q;
    assign dato_valido         = valido_q;
    assign ocupado             = ocupado_q;
    assign corte_terminado     = terminado_q;
    assign error_sin_fin       = sin_fin_q;
    assign palabras_entregadas = cuenta_q;

endmodule
